// File: rtl/viterbi_frame_ctrl_pkg.sv
// Shared receiver definitions for the Viterbi frame sequencer: state encoding and sizing defaults.
package viterbi_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRST  = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } vfc_state_e;

  localparam int TB_DEPTH_DEF = 35;
  localparam int LEN_W_DEF    = 12;

endpackage

// File: rtl/viterbi_frame_ctrl.sv
// Frames a rate-1/2 coded stream into the Viterbi decoder: reset, feed, zero flush, output qualify.
// Inputs accepted only in FEED (InValid low stalls the decoder); one DRST cycle and one DONE cycle per frame.
module viterbi_frame_ctrl
  import viterbi_frame_ctrl_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_frame,
  input  logic [LEN_W-1:0] i_num_bits,
  input  logic             i_in_valid,
  input  logic             i_in_bit,
  output logic             o_in_ready,
  output logic             o_dec_in,
  output logic             o_dec_enable,
  output logic             o_dec_reset,
  input  logic             i_dec_out,
  output logic             o_out_bit,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int TOT_W = LEN_W + 1;

  vfc_state_e       r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_in_pairs, w_in_pairs_nxt;
  logic [LEN_W-1:0] r_out_cnt, w_out_cnt_nxt;
  logic [TOT_W-1:0] r_tot_pairs, w_tot_pairs_nxt;
  logic             r_phase, w_phase_nxt;

  logic             w_dec_en;
  logic             w_out_valid;
  logic [LEN_W-1:0] w_in_pairs_inc;
  logic [LEN_W-1:0] w_out_cnt_inc;

  assign w_in_pairs_inc = r_in_pairs + LEN_W'(1);
  assign w_out_cnt_inc  = r_out_cnt + LEN_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_in_pairs  <= '0;
      r_out_cnt   <= '0;
      r_tot_pairs <= '0;
      r_phase     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_in_pairs  <= w_in_pairs_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_tot_pairs <= w_tot_pairs_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_in_pairs_nxt  = r_in_pairs;
    w_out_cnt_nxt   = r_out_cnt;
    w_tot_pairs_nxt = r_tot_pairs;
    w_phase_nxt     = r_phase;
    o_in_ready      = 1'b0;
    o_dec_in        = 1'b0;
    o_dec_reset     = 1'b0;
    o_frame_done    = 1'b0;
    w_dec_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start_frame) begin
          w_len_nxt       = i_num_bits;
          w_in_pairs_nxt  = '0;
          w_out_cnt_nxt   = '0;
          w_tot_pairs_nxt = '0;
          w_phase_nxt     = 1'b0;
          w_state_nxt     = ST_DRST;
        end
      end
      ST_DRST: begin
        o_dec_reset = 1'b1;
        w_state_nxt = (r_len == '0) ? ST_DONE : ST_FEED;
      end
      ST_FEED: begin
        o_in_ready = 1'b1;
        w_dec_en   = i_in_valid;
        o_dec_in   = i_in_bit;
      end
      ST_FLUSH: begin
        w_dec_en = 1'b1;
      end
      ST_DONE: begin
        o_frame_done = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Decoded bit of pair k-TB_DEPTH appears on the B cycle of pair k.
    w_out_valid = w_dec_en && r_phase && (r_tot_pairs >= TOT_W'(TB_DEPTH)) && (r_out_cnt < r_len);

    if (w_dec_en) begin
      w_phase_nxt = ~r_phase;
      if (r_phase) begin
        w_tot_pairs_nxt = r_tot_pairs + TOT_W'(1);
        if (r_state == ST_FEED) begin
          w_in_pairs_nxt = w_in_pairs_inc;
          if (w_in_pairs_inc == r_len) w_state_nxt = ST_FLUSH;
        end
      end
    end

    if (w_out_valid) begin
      w_out_cnt_nxt = w_out_cnt_inc;
      if (w_out_cnt_inc == r_len) w_state_nxt = ST_DONE;
    end
  end

  assign o_dec_enable = w_dec_en;
  assign o_out_valid  = w_out_valid;
  assign o_out_bit    = i_dec_out;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench: short-depth controller for framing checks, depth-35 controller with a behavioural K=7 decoder end to end.
module tb_viterbi_frame_ctrl;

  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start4, start35, in_valid, in_bit;
  logic [11:0] num_bits;
  logic rdy4, din4, en4, drst4, obit4, ovld4, busy4, done4;
  logic rdy35, din35, en35, drst35, obit35, ovld35, busy35, done35;
  logic dec_out4, dec_out35;
  logic [4:0] lf = 5'h1;

  int checks = 0;
  int errors = 0;

  viterbi_frame_ctrl #(.TB_DEPTH(4), .LEN_W(12)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_frame(start4), .i_num_bits(num_bits),
    .i_in_valid(in_valid), .i_in_bit(in_bit), .o_in_ready(rdy4), .o_dec_in(din4),
    .o_dec_enable(en4), .o_dec_reset(drst4), .i_dec_out(dec_out4), .o_out_bit(obit4),
    .o_out_valid(ovld4), .o_busy(busy4), .o_frame_done(done4));

  viterbi_frame_ctrl #(.TB_DEPTH(35), .LEN_W(12)) dut35 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_frame(start35), .i_num_bits(num_bits),
    .i_in_valid(in_valid), .i_in_bit(in_bit), .o_in_ready(rdy35), .o_dec_in(din35),
    .o_dec_enable(en35), .o_dec_reset(drst35), .i_dec_out(dec_out35), .o_out_bit(obit35),
    .o_out_valid(ovld35), .o_busy(busy35), .o_frame_done(done35));

  // Arbitrary changing decoder output for the short-depth instance.
  always @(posedge clk) lf <= {lf[3:0], lf[4] ^ lf[2]};
  assign dec_out4 = lf[0];

  // Behavioural register-exchange Viterbi decoder, K=7, hard decision.
  int         pm[64];
  logic [63:0] hist[64];
  logic       dph, ra;
  int         best, bmin;

  function automatic int bm(input logic [6:0] r, input logic a, input logic b);
    return (((^(r & G0)) != a) ? 1 : 0) + (((^(r & G1)) != b) ? 1 : 0);
  endfunction
  function automatic logic [5:0] pred(input int n, input logic x);
    logic [5:0] t;
    t = 6'(n);
    return {t[4:0], x};
  endfunction
  function automatic logic [6:0] regv(input int n, input logic x);
    logic [5:0] t;
    t = 6'(n);
    return {t[5], t[4:0], x};
  endfunction

  always @(posedge clk) begin
    if (drst35) begin
      dph <= 1'b0;
      ra  <= 1'b0;
      for (int s = 0; s < 64; s++) begin
        pm[s]   <= (s == 0) ? 0 : 1000;
        hist[s] <= '0;
      end
    end else if (en35) begin
      dph <= ~dph;
      if (!dph) ra <= din35;
      else begin
        for (int n = 0; n < 64; n++) begin
          if (pm[pred(n,1'b1)] + bm(regv(n,1'b1), ra, din35) < pm[pred(n,1'b0)] + bm(regv(n,1'b0), ra, din35)) begin
            pm[n]   <= pm[pred(n,1'b1)] + bm(regv(n,1'b1), ra, din35);
            hist[n] <= {hist[pred(n,1'b1)][62:0], (n >= 32) ? 1'b1 : 1'b0};
          end else begin
            pm[n]   <= pm[pred(n,1'b0)] + bm(regv(n,1'b0), ra, din35);
            hist[n] <= {hist[pred(n,1'b0)][62:0], (n >= 32) ? 1'b1 : 1'b0};
          end
        end
      end
    end
  end

  always_comb begin
    best = 0;
    bmin = pm[0];
    for (int s = 1; s < 64; s++) begin
      if (pm[s] < bmin) begin
        bmin = pm[s];
        best = s;
      end
    end
    dec_out35 = hist[best][34];
  end

  // Observations of one short-depth frame, filled by run_frame4.
  int done_cyc, rst_cyc, nvalid, stall_vld, din_err, obit_err, nready, fed;
  logic [127:0] vmask;
  logic [6:0]   snap;

  task automatic run_frame4(input logic [11:0] nb, input bit stall, input bit mid_start, input bit rst_flush);
    logic [31:0] pat;
    bit stall_now;
    pat = 32'hB53C96E1;
    done_cyc = -1; rst_cyc = -1; nvalid = 0; stall_vld = 0; din_err = 0;
    obit_err = 0; nready = 0; fed = 0; vmask = '0; snap = '1;
    @(posedge clk); #1 start4 = 1'b1; num_bits = nb; in_valid = 1'b0;
    @(posedge clk); #1 start4 = 1'b0; num_bits = 12'd3;
    for (int c = 1; c < 80; c++) begin
      stall_now = stall && (c % 3 == 0);
      start4    = mid_start && (c == 6);
      in_valid  = (fed < 2 * int'(nb)) && !stall_now;
      in_bit    = pat[fed % 32];
      if (rst_flush && c == 20) begin
        rst_n = 1'b0;
        #1 snap = {busy4, rdy4, en4, drst4, ovld4, done4, din4};
        #1 rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      if (drst4 && rst_cyc < 0) rst_cyc = c;
      if (rdy4) nready++;
      if (ovld4) begin
        nvalid++;
        vmask[c] = 1'b1;
        if (stall_now && rdy4) stall_vld++;
      end
      if (en4 && rdy4) begin
        if (din4 !== in_bit) din_err++;
        fed++;
      end
      if (obit4 !== dec_out4) obit_err++;
      if (done4) done_cyc = c;
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    start4 = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start4 = 1'b0; start35 = 1'b0; num_bits = '0; in_valid = 1'b0; in_bit = 1'b0;
    #3;
    checks++; if ({busy4, rdy4, en4, drst4, din4, ovld4, done4} !== 7'b0) begin errors++; $display("FAIL reset_outs got %b want 0000000", {busy4, rdy4, en4, drst4, din4, ovld4, done4}); end
    checks++; if ({busy35, rdy35, en35, drst35, ovld35, done35} !== 6'b0) begin errors++; $display("FAIL reset_outs35 got %b want 000000", {busy35, rdy35, en35, drst35, ovld35, done35}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b want 0", busy4); end
  endtask

  task automatic test_basic;
    logic [127:0] exp_mask;
    exp_mask = '0;
    for (int p = 4; p < 12; p++) exp_mask[3 + 2 * p] = 1'b1;
    run_frame4(12'd8, 1'b0, 1'b0, 1'b0);
    checks++; if (rst_cyc !== 1) begin errors++; $display("FAIL basic_decreset_cycle got %0d want 1", rst_cyc); end
    checks++; if (nvalid !== 8) begin errors++; $display("FAIL basic_nvalid got %0d want 8", nvalid); end
    checks++; if (vmask !== exp_mask) begin errors++; $display("FAIL basic_valid_cycles got %h want %h", vmask, exp_mask); end
    checks++; if (done_cyc !== 26) begin errors++; $display("FAIL basic_done_cycle got %0d want 26", done_cyc); end
    checks++; if (nready !== 16) begin errors++; $display("FAIL basic_ready_cycles got %0d want 16", nready); end
    checks++; if (din_err !== 0 || fed !== 16) begin errors++; $display("FAIL basic_decin got err %0d fed %0d want 0 16", din_err, fed); end
    checks++; if (obit_err !== 0) begin errors++; $display("FAIL basic_outbit got %0d diffs want 0", obit_err); end
    @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL basic_idle_after got %b want 0", busy4); end
  endtask

  task automatic test_stalls;
    logic [127:0] exp_mask;
    exp_mask = '0;
    exp_mask[16] = 1'b1; exp_mask[19] = 1'b1; exp_mask[22] = 1'b1; exp_mask[25] = 1'b1;
    exp_mask[27] = 1'b1; exp_mask[29] = 1'b1; exp_mask[31] = 1'b1; exp_mask[33] = 1'b1;
    run_frame4(12'd8, 1'b1, 1'b0, 1'b0);
    checks++; if (nvalid !== 8) begin errors++; $display("FAIL stall_nvalid got %0d want 8", nvalid); end
    checks++; if (stall_vld !== 0) begin errors++; $display("FAIL stall_valid_in_stall got %0d want 0", stall_vld); end
    checks++; if (vmask !== exp_mask) begin errors++; $display("FAIL stall_valid_cycles got %h want %h", vmask, exp_mask); end
    checks++; if (din_err !== 0 || fed !== 16) begin errors++; $display("FAIL stall_decin got err %0d fed %0d want 0 16", din_err, fed); end
    checks++; if (done_cyc !== 34) begin errors++; $display("FAIL stall_done_cycle got %0d want 34", done_cyc); end
  endtask

  task automatic test_zero_length;
    run_frame4(12'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (rst_cyc !== 1) begin errors++; $display("FAIL zero_decreset_cycle got %0d want 1", rst_cyc); end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL zero_done_cycle got %0d want 2", done_cyc); end
    checks++; if (nready !== 0 || nvalid !== 0) begin errors++; $display("FAIL zero_activity got ready %0d valid %0d want 0 0", nready, nvalid); end
  endtask

  task automatic test_start_while_busy;
    run_frame4(12'd8, 1'b0, 1'b1, 1'b0);
    checks++; if (nvalid !== 8) begin errors++; $display("FAIL busy_start_nvalid got %0d want 8", nvalid); end
    checks++; if (done_cyc !== 26) begin errors++; $display("FAIL busy_start_done got %0d want 26", done_cyc); end
  endtask

  task automatic test_reset_mid_frame;
    run_frame4(12'd8, 1'b0, 1'b0, 1'b1);
    checks++; if (snap !== 7'b0) begin errors++; $display("FAIL rst_flush_outs got %b want 0000000", snap); end
    @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_flush_idle got %b want 0", busy4); end
    run_frame4(12'd8, 1'b0, 1'b0, 1'b0);
    checks++; if (nvalid !== 8 || done_cyc !== 26) begin errors++; $display("FAIL rst_flush_next_frame got valid %0d done %0d want 8 26", nvalid, done_cyc); end
  endtask

  task automatic test_end_to_end;
    logic [63:0]  msg, rx;
    logic [127:0] coded;
    logic [5:0]   s;
    logic [6:0]   r;
    int nout, ndone, nfed, first_c, done_c;
    msg = 64'hA5C3_96F0_1E2D_3B40;
    s = '0;
    for (int i = 0; i < 64; i++) begin
      r = {msg[63 - i], s};
      coded[2 * i]     = ^(r & G0);
      coded[2 * i + 1] = ^(r & G1);
      s = {msg[63 - i], s[5:1]};
    end
    rx = '0; nout = 0; ndone = 0; nfed = 0; first_c = -1; done_c = -1;
    @(posedge clk); #1 start35 = 1'b1; num_bits = 12'd64;
    @(posedge clk); #1 start35 = 1'b0;
    for (int c = 1; c < 230; c++) begin
      in_valid = (nfed < 128);
      in_bit   = coded[nfed % 128];
      @(negedge clk);
      if (en35 && rdy35) nfed++;
      if (ovld35) begin
        if (nout < 64) rx[63 - nout] = obit35;
        if (nout == 0) first_c = c;
        nout++;
      end
      if (done35) begin ndone++; done_c = c; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (nout !== 64) begin errors++; $display("FAIL e2e_nvalid got %0d want 64", nout); end
    checks++; if (rx !== msg) begin errors++; $display("FAIL e2e_decoded got %h want %h", rx, msg); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL e2e_done_count got %0d want 1", ndone); end
    checks++; if (first_c !== 73) begin errors++; $display("FAIL e2e_first_valid got %0d want 73", first_c); end
    checks++; if (done_c !== 200) begin errors++; $display("FAIL e2e_done_cycle got %0d want 200", done_c); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stalls;
    test_zero_length;
    test_start_while_busy;
    test_reset_mid_frame;
    test_end_to_end;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer for the receiver's Viterbi decoder. It accepts the rate-1/2 coded bit stream one bit per cycle with a valid/ready handshake and issues the decoder reset at frame start. It gates the decoder with a clock enable, appends zero flush pairs so traceback drains, and qualifies the decoder's serial output so exactly the frame's decoded bits leave marked valid. It sits between the deinterleaver output buffer and the descrambler.

## Interface
- `TB_DEPTH`, default 35: decoder latency in decoded bits (pairs); also the number of zero flush pairs.
- `LEN_W`, default 12: width of the frame-length field.

- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `StartFrame` in 1: one-cycle start pulse; honoured only in IDLE.
- `NumBits` in LEN_W: decoded bits in the frame, including tail; latched on an accepted StartFrame.
- `InValid` in 1: coded bit present on InBit.
- `InBit` in 1: coded bit, serial, A then B of each pair.
- `InReady` out 1: controller accepts InBit this cycle.
- `DecIn` out 1: bit driven to the decoder.
- `DecEnable` out 1: decoder clock enable.
- `DecReset` out 1: active-high synchronous reset to the decoder.
- `DecOut` in 1: decoder serial output.
- `OutBit` out 1: decoded bit, equal to DecOut.
- `OutValid` out 1: OutBit is a frame bit.
- `Busy` out 1: high in any state other than IDLE.
- `FrameDone` out 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE, DRST, FEED, FLUSH, DONE.
- IDLE: when StartFrame=1, latch NumBits into len, clear counters, go to DRST.
- DRST: DecReset=1 for exactly one cycle. Next state is FEED, or DONE directly if len=0.
- FEED: InReady=1; DecEnable = InValid; DecIn = InBit.
  - Each enabled cycle toggles phase (0 = A, 1 = B).
  - On a B cycle, in_pairs increments.
  - When in_pairs reaches len on a B cycle, go to FLUSH.
- FLUSH: InReady=0; DecEnable=1; DecIn=0; phase and pair counting continue. Stay until out_cnt reaches len.
- Output qualification: OutValid = DecEnable & phase=1 & (total pairs completed before this one ≥ TB_DEPTH) & out_cnt < len.
  - out_cnt increments on each OutValid.
  - When the final valid bit is emitted, go to DONE.
- DONE: FrameDone=1 for one cycle, then IDLE.
- Counter widths: in_pairs and out_cnt are LEN_W bits. The total pair counter is LEN_W+1 bits, which is enough because len + TB_DEPTH must fit in it.
- Boundaries:
  - StartFrame outside IDLE is ignored.
  - InValid low in FEED stalls everything, including phase and OutValid.
  - A stall between A and B of a pair is legal.
  - Reset low at any time forces IDLE immediately and clears all counters. DecReset is not pulsed; the next frame's DRST handles it.

## Timing
- Reset values: InReady=0, DecEnable=0, DecReset=0, DecIn=0, OutValid=0, Busy=0, FrameDone=0, state=IDLE.
- StartFrame sampled at edge t: DecReset=1 in cycle t+1; InReady=1 from cycle t+2.
- State, counters and phase are registered.
- InReady, DecEnable, DecIn, OutBit and OutValid are combinational from state, counters and inputs; there are no extra pipeline stages.
- Latency: the first OutValid comes on the B cycle of pair index TB_DEPTH (0-based).
- With no stalls, a frame occupies 1 + 2·(len+TB_DEPTH) + 1 cycles after StartFrame, then returns to IDLE.
- FrameDone is asserted in the cycle after the last OutValid.

## Structure
- Shared receiver package holds:
  - the state encoding (IDLE/DRST/FEED/FLUSH/DONE);
  - the default TB_DEPTH constant;
  - the LEN_W constant.
- No sub-module: the FSM and three counters live in one module. The decoder is instantiated by the parent, not inside this block.

## Test plan
- **Basic frame:** TB_DEPTH=4, NumBits=8, 16 coded bits with InValid held high.
  - DecReset at t+1.
  - Exactly 8 OutValid pulses, on B cycles of pairs 4–11.
  - FrameDone at t+26 (2·12 enable cycles + DRST + 1).
- **Stalls:** same frame with InValid low on every third cycle, including between A and B. OutValid count is still 8, none during stall cycles, and DecIn sequence equals the input sequence.
- **Zero length:** NumBits=0. Sequence is DRST then DONE: FrameDone at t+2, no InReady and no OutValid.
- **Start while busy:** a StartFrame pulse mid-FEED is ignored; len stays 8 and exactly 8 bits are output.
- **Reset mid-frame:** Reset low in FLUSH gives immediate IDLE and all outputs 0. A new 8-bit frame afterwards completes normally.
- **End to end:** real decoder with TB_DEPTH=35 and a 64-bit known message encoded at K=7 (133/171), tail included. Decoded OutBit sequence equals the message and FrameDone fires once.
